ball_motion_engine: RTL and testbench

Parametrised successor to the ball direction/collision logic. Once per frame it runs up to four brick probes through the brick memory, then resolves wall, platform and brick bounces into the two direction bits. It also reports hit bricks to the brick-damage logic and flags a missed ball to the game controller. It sits between the ball position registers, the brick RAM lookup (coordinate → brick index/health) and the frame controller that pulses `start`.

---
 rtl/ball_motion_engine.sv | 151 +++++++++++++++
 tb/tb_ball_motion_engine.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ball_motion_engine.sv
// ball_motion_engine: per-frame brick probing and wall/platform/brick bounce resolution
module ball_motion_engine #(
  parameter int W      = 10,
  parameter int X_MAX  = 160,
  parameter int Y_MAX  = 120,
  parameter int SIZE   = 4,
  parameter int PLAT_Y = 64,
  parameter int PLAT_W = 20,
  parameter int HP_W   = 2,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [W-1:0]    ball_x,
  input  logic [W-1:0]    ball_y,
  input  logic [W-1:0]    plat_x,
  output logic [W-1:0]    probe_x,
  output logic [W-1:0]    probe_y,
  input  logic [W-1:0]    brick_x,
  input  logic [W-1:0]    brick_y,
  input  logic [HP_W-1:0] health,
  output logic            x_dir,
  output logic            y_dir,
  output logic            busy,
  output logic            done,
  output logic            hit_y_valid,
  output logic            hit_x_valid,
  output logic [W-1:0]    hit_y_bx,
  output logic [W-1:0]    hit_y_by,
  output logic [W-1:0]    hit_x_bx,
  output logic [W-1:0]    hit_x_by,
  output logic            plat_hit,
  output logic            miss
);
  typedef enum logic [2:0] {IDLE, PY0, PY1, PX0, PX1, RESOLVE} state_t;
  localparam logic [W-1:0] SZ  = W'(SIZE);
  localparam logic [W-1:0] XM  = W'(X_MAX);
  localparam logic [W-1:0] YM  = W'(Y_MAX);
  localparam logic [W-1:0] PY  = W'(PLAT_Y);
  localparam logic [W-1:0] PW  = W'(PLAT_W);
  localparam logic [1:0]   LAT = 2'(RD_LAT);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [W-1:0] probe_x_q, probe_y_q, pt_x, pt_y, x_lead, y_lead;
  logic x_dir_q, y_dir_q, x_dir_d, y_dir_d, done_q, plat_q, miss_q;
  logic hyv_q, hxv_q;
  logic [W-1:0] hybx_q, hyby_q, hxbx_q, hxby_q;
  logic x_skip, y_skip, probing, addr, last, hit, accept, res, y_phase;
  logic x_wall0, x_wall1, y_wall0, y_wall1, plat_c;
  state_t x_first;
  assign y_lead  = y_dir_q ? ball_y + SZ : ball_y - 1'b1;
  assign x_lead  = x_dir_q ? ball_x + SZ : ball_x - 1'b1;
  assign y_skip  = y_dir_q ? (ball_y + SZ >= YM) : (ball_y == '0);
  assign x_skip  = x_dir_q ? (ball_x + SZ >= XM) : (ball_x == '0);
  assign x_first = x_skip ? RESOLVE : PX0;
  assign probing = state_q inside {PY0, PY1, PX0, PX1};
  assign y_phase = state_q inside {PY0, PY1};
  assign addr    = probing && cnt_q == 2'd0;
  assign last    = probing && cnt_q == LAT;
  assign hit     = last && health != '0;
  assign accept  = state_q == IDLE && start && !done_q;
  assign res     = state_q == RESOLVE;
  assign pt_x    = y_phase ? (state_q == PY1 ? ball_x + SZ - 1'b1 : ball_x) : x_lead;
  assign pt_y    = y_phase ? y_lead : (state_q == PX1 ? ball_y + SZ - 1'b1 : ball_y);
  assign probe_x = addr ? pt_x : probe_x_q;
  assign probe_y = addr ? pt_y : probe_y_q;
  assign x_wall0 = ball_x == '0;
  assign x_wall1 = ball_x >= XM - SZ;
  assign y_wall0 = ball_y == '0;
  assign y_wall1 = ball_y >= YM - SZ;
  assign plat_c  = y_dir_q && ball_y + SZ == PY && ball_x + SZ > plat_x && ball_x < plat_x + PW;
  assign x_dir_d = x_wall0 ? 1'b1 : x_wall1 ? 1'b0 : hxv_q ? ~x_dir_q : x_dir_q;
  assign y_dir_d = y_wall0 ? 1'b1 : (y_wall1 || plat_c) ? 1'b0 : hyv_q ? ~y_dir_q : y_dir_q;
  assign x_dir       = x_dir_q;
  assign y_dir       = y_dir_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign plat_hit    = plat_q;
  assign miss        = miss_q;
  assign hit_y_valid = hyv_q;
  assign hit_x_valid = hxv_q;
  assign hit_y_bx    = hybx_q;
  assign hit_y_by    = hyby_q;
  assign hit_x_bx    = hxbx_q;
  assign hit_x_by    = hxby_q;
  // Next state: skipped probes cost zero cycles, so transitions jump straight past them
  always_comb begin
    state_d = state_q;
    cnt_d   = (probing && !last) ? cnt_q + 2'd1 : 2'd0;
    case (state_q)
      IDLE:    if (accept) state_d = y_skip ? x_first : PY0;
      PY0:     if (last) state_d = hit ? x_first : PY1;
      PY1:     if (last) state_d = x_first;
      PX0:     if (last) state_d = hit ? RESOLVE : PX1;
      PX1:     if (last) state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, directions, pulses, probe hold and hit latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      x_dir_q   <= 1'b0;
      y_dir_q   <= 1'b0;
      done_q    <= 1'b0;
      plat_q    <= 1'b0;
      miss_q    <= 1'b0;
      probe_x_q <= '0;
      probe_y_q <= '0;
      hyv_q     <= 1'b0;
      hxv_q     <= 1'b0;
      hybx_q    <= '0;
      hyby_q    <= '0;
      hxbx_q    <= '0;
      hxby_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= res;
      miss_q  <= res && !y_wall0 && y_wall1;
      plat_q  <= res && !y_wall0 && !y_wall1 && plat_c;
      if (res) begin
        x_dir_q <= x_dir_d;
        y_dir_q <= y_dir_d;
      end
      if (addr) begin
        probe_x_q <= pt_x;
        probe_y_q <= pt_y;
      end
      if (accept) begin
        hyv_q  <= 1'b0;
        hxv_q  <= 1'b0;
        hybx_q <= '0;
        hyby_q <= '0;
        hxbx_q <= '0;
        hxby_q <= '0;
      end else if (hit && y_phase) begin
        hyv_q  <= 1'b1;
        hybx_q <= brick_x;
        hyby_q <= brick_y;
      end else if (hit) begin
        hxv_q  <= 1'b1;
        hxbx_q <= brick_x;
        hxby_q <= brick_y;
      end
    end
  end
endmodule

// File: tb/tb_ball_motion_engine.sv
// tb_ball_motion_engine: directed frames against a one-cycle-latency brick memory model
module tb_ball_motion_engine;
  logic clk = 0, reset = 0, start = 0;
  logic [9:0] ball_x = 0, ball_y = 0, plat_x = 0;
  logic [9:0] probe_x, probe_y, brick_x, brick_y;
  logic [1:0] health;
  logic x_dir, y_dir, busy, done, hit_y_valid, hit_x_valid, plat_hit, miss;
  logic [9:0] hit_y_bx, hit_y_by, hit_x_bx, hit_x_by;
  logic [9:0] px_q = 0, py_q = 0;
  int mode = 0;
  int vectors = 0, miscompares = 0;
  logic [9:0] pxa [0:63];
  logic [9:0] pya [0:63];
  int lat, dn, dl;
  logic pl, ms;

  ball_motion_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .plat_x(plat_x),
    .probe_x(probe_x), .probe_y(probe_y),
    .brick_x(brick_x), .brick_y(brick_y), .health(health),
    .x_dir(x_dir), .y_dir(y_dir), .busy(busy), .done(done),
    .hit_y_valid(hit_y_valid), .hit_x_valid(hit_x_valid),
    .hit_y_bx(hit_y_bx), .hit_y_by(hit_y_by), .hit_x_bx(hit_x_bx), .hit_x_by(hit_x_by),
    .plat_hit(plat_hit), .miss(miss)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] hp(input logic [9:0] x, input logic [9:0] y, input int m);
    return m == 2 ? 2'd3 : (m == 1 && x == 10'd50 && y == 10'd34) ? 2'd2 : 2'd0;
  endfunction

  always @(posedge clk) begin
    px_q <= probe_x;
    py_q <= probe_y;
  end
  assign health  = hp(px_q, py_q, mode);
  assign brick_x = px_q >> 3;
  assign brick_y = py_q >> 3;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic run_frame(input logic [9:0] bx, input logic [9:0] by, input logic [9:0] px, input int md);
    @(posedge clk); #1;
    ball_x = bx; ball_y = by; plat_x = px; mode = md;
    lat = -1; pl = 0; ms = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      pxa[n] = probe_x;
      pya[n] = probe_y;
      if (done) begin lat = n; pl = plat_hit; ms = miss; break; end
    end
  endtask

  initial begin
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_dirs", {x_dir, y_dir}, 0);
    chk("rst_done", {done, plat_hit, miss}, 0);
    chk("rst_hits", {hit_y_valid, hit_x_valid, hit_y_bx, hit_x_by}, 0);
    chk("rst_probe", {probe_x, probe_y}, 0);
    reset = 0;
    run_frame(50, 30, 0, 0);
    chk("f1_lat", lat, 9);
    chk("f1_p0", {pxa[0], pya[0]}, {10'd50, 10'd29});
    chk("f1_p1", {pxa[2], pya[2]}, {10'd53, 10'd29});
    chk("f1_p2", {pxa[4], pya[4]}, {10'd49, 10'd30});
    chk("f1_p3", {pxa[6], pya[6]}, {10'd49, 10'd33});
    chk("f1_hold", {pxa[7], pya[7]}, {10'd49, 10'd33});
    chk("f1_dirs", {x_dir, y_dir}, 2'b00);
    chk("f1_busy", busy, 0);
    run_frame(0, 0, 0, 0);
    chk("f2_lat", lat, 1);
    chk("f2_dirs", {x_dir, y_dir}, 2'b11);
    run_frame(50, 30, 0, 1);
    chk("f3_lat", lat, 7);
    chk("f3_p0", {pxa[0], pya[0]}, {10'd50, 10'd34});
    chk("f3_p1", {pxa[2], pya[2]}, {10'd54, 10'd30});
    chk("f3_hy", {hit_y_valid, hit_y_bx, hit_y_by}, {1'b1, 10'd6, 10'd4});
    chk("f3_hx", hit_x_valid, 0);
    chk("f3_dirs", {x_dir, y_dir}, 2'b10);
    run_frame(156, 30, 0, 2);
    chk("f4_lat", lat, 3);
    chk("f4_dirs", {x_dir, y_dir}, 2'b01);
    chk("f4_hy", {hit_y_valid, hit_y_bx, hit_y_by}, {1'b1, 10'd19, 10'd3});
    chk("f4_hx", hit_x_valid, 0);
    run_frame(10, 60, 12, 0);
    chk("f5_lat", lat, 9);
    chk("f5_plat", {pl, ms}, 2'b10);
    chk("f5_dirs", {x_dir, y_dir}, 2'b00);
    chk("f5_hits_clr", {hit_y_valid, hit_y_bx}, 0);
    @(posedge clk); #1;
    chk("f5_plat_pulse", plat_hit, 0);
    run_frame(10, 0, 14, 0);
    chk("f6_lat", lat, 5);
    chk("f6_dirs", {x_dir, y_dir}, 2'b01);
    run_frame(10, 60, 14, 0);
    chk("f7_lat", lat, 9);
    chk("f7_noplat", pl, 0);
    chk("f7_dirs", {x_dir, y_dir}, 2'b01);
    run_frame(10, 116, 14, 0);
    chk("f8_lat", lat, 5);
    chk("f8_miss", {ms, pl}, 2'b10);
    chk("f8_dirs", {x_dir, y_dir}, 2'b00);
    run_frame(0, 0, 14, 0);
    chk("f9_dirs", {x_dir, y_dir}, 2'b11);
    @(posedge clk); #1;
    ball_x = 50; ball_y = 30; mode = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("r_px0_probe", {probe_x, probe_y}, {10'd54, 10'd30});
    chk("r_pre_hit", hit_y_valid, 1);
    reset = 1;
    #1;
    chk("r_busy", busy, 0);
    chk("r_dirs", {x_dir, y_dir}, 0);
    chk("r_hits", {hit_y_valid, hit_y_bx, hit_y_by}, 0);
    chk("r_probe", {probe_x, probe_y}, 0);
    @(posedge clk); #1;
    reset = 0;
    mode = 0;
    @(posedge clk); #1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    dn = 0; dl = -1;
    for (int n = 0; n < 30; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (done) begin dn++; if (dl < 0) dl = n; end
      start = (n == 2) || done;
    end
    start = 0;
    chk("d_count", dn, 1);
    chk("d_lat", dl, 9);
    chk("d_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
